// File: rtl/norm1_seq.sv
// norm1_seq: turns one RMSNorm command into start1/start1_sum/start2 pulses.
// Optional watchdog enabled by defining NORM1_SEQ_TIMEOUT_EN.
module norm1_seq #(
  parameter int ADDR_W      = 10,
  parameter int TILE_W      = 6,
  parameter int ADDR_STRIDE = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_prefill,
  input  logic [TILE_W-1:0] cmd_num_tiles,
  input  logic [ADDR_W-1:0] cmd_rd_base,
  input  logic [ADDR_W-1:0] cmd_wb_base,
  output logic              state_prefill,
  output logic              state_decode,
  output logic              start1,
  output logic              start1_sum,
  output logic              start2,
  input  logic              busy_norm1,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              done,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ADDR_STRIDE);

  typedef enum logic [2:0] {
    IDLE, P1_ISS, P1_WAIT, SUM_ISS,
    SUM_WAIT, P2_ISS, P2_WAIT, DONE_S
  } state_t;

  state_t state, next_state;
  logic [TILE_W-1:0] tile, next_tile, num_tiles;
  logic [CNT_W-1:0] wait_cnt;
  logic prefill;
  logic [ADDR_W-1:0] rd_base, wb_base, offset;
  logic accept, in_wait, wait_exit, last, to_hit;

  assign accept = cmd_valid && (state == IDLE);
  assign in_wait = (state == P1_WAIT) || (state == SUM_WAIT)
                || (state == P2_WAIT);
  // First WAIT cycle ignores busy: the controller raises it one cycle late.
  assign wait_exit = in_wait && !busy_norm1 && (wait_cnt != '0);
  assign last = (tile == num_tiles - TILE_W'(1));
  assign offset = ADDR_W'(tile) * STRIDE;

`ifdef NORM1_SEQ_TIMEOUT_EN
  assign to_hit = in_wait && !wait_exit
               && (wait_cnt >= CNT_W'(TIMEOUT));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    next_tile  = tile;
    unique case (state)
      IDLE: if (cmd_valid) begin
        next_tile  = '0;
        next_state = (cmd_num_tiles == '0) ? DONE_S : P1_ISS;
      end
      P1_ISS: next_state = P1_WAIT;
      P1_WAIT: begin
        if (to_hit) next_state = DONE_S;
        else if (wait_exit) begin
          if (last) begin
            next_tile  = '0;
            next_state = SUM_ISS;
          end else begin
            next_tile  = tile + TILE_W'(1);
            next_state = P1_ISS;
          end
        end
      end
      SUM_ISS: next_state = SUM_WAIT;
      SUM_WAIT: begin
        if (to_hit) next_state = DONE_S;
        else if (wait_exit) next_state = P2_ISS;
      end
      P2_ISS: next_state = P2_WAIT;
      P2_WAIT: begin
        if (to_hit) next_state = DONE_S;
        else if (wait_exit) begin
          if (last) next_state = DONE_S;
          else begin
            next_tile  = tile + TILE_W'(1);
            next_state = P2_ISS;
          end
        end
      end
      DONE_S: if (wait_cnt != '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tile      <= '0;
      wait_cnt  <= '0;
      prefill   <= 1'b0;
      num_tiles <= '0;
      rd_base   <= '0;
      wb_base   <= '0;
    end else begin
      state <= next_state;
      tile  <= next_tile;
      if (state != next_state) wait_cnt <= '0;
      else if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
      if (accept) begin
        prefill   <= cmd_prefill;
        num_tiles <= cmd_num_tiles;
        rd_base   <= cmd_rd_base;
        wb_base   <= cmd_wb_base;
      end
    end
  end

`ifdef NORM1_SEQ_TIMEOUT_EN
  logic err;
  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else if (accept) err <= 1'b0;
    else if (to_hit) err <= 1'b1;
  end
  assign err_timeout = err;
`else
  assign err_timeout = 1'b0;
`endif

  assign cmd_ready     = (state == IDLE);
  assign state_prefill = (state != IDLE) && prefill;
  assign state_decode  = (state != IDLE) && !prefill;
  assign start1        = (state == P1_ISS);
  assign start1_sum    = (state == SUM_ISS);
  assign start2        = (state == P2_ISS);
  assign sram_rd_en    = start1 || start2;
  assign sram_rd_addr  = sram_rd_en ? rd_base + offset : '0;
  assign wb_valid      = (state == P2_WAIT) && wait_exit;
  assign wb_addr       = wb_valid ? wb_base + offset : '0;
  // DONE lasts two cycles; done pulses on the second.
  assign done          = (state == DONE_S) && (wait_cnt != '0);

endmodule
